// File: rtl/distram_clr.sv
// distram_clr: dual-port distributed RAM with a built-in clear sequencer.
// Port A reads and writes with per-bit enables; port B is read-only.
module distram_clr #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned READ_REG   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   output logic                  busy,
   input  logic [DEPTH_LOG2-1:0] a_addr,
   output logic [WIDTH-1:0]      a_rddata,
   input  logic [WIDTH-1:0]      a_wrdata,
   input  logic [WIDTH-1:0]      a_wren,
   input  logic [DEPTH_LOG2-1:0] b_addr,
   output logic [WIDTH-1:0]      b_rddata
);

   localparam int unsigned DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] LAST = {DEPTH_LOG2{1'b1}};

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_CLEARING = 1'b1
   } state_e;

   state_e                state_q;
   state_e                state_d;
   logic [DEPTH_LOG2-1:0] cnt_q;
   logic [DEPTH_LOG2-1:0] cnt_d;

   logic [WIDTH-1:0]      mem_q [DEPTH];

   logic                  we;
   logic [DEPTH_LOG2-1:0] waddr;
   logic [WIDTH-1:0]      wdata;
   logic [WIDTH-1:0]      a_mem;
   logic [WIDTH-1:0]      b_mem;

   assign busy  = (state_q == ST_CLEARING);
   assign a_mem = mem_q[a_addr];
   assign b_mem = mem_q[b_addr];

   // Sequencer state; reset always (re)starts a clear from entry 0
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEARING;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: walk every entry once, ignore clear while walking
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clear) begin
               state_d = ST_CLEARING;
               cnt_d   = '0;
            end
         end
         ST_CLEARING: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // Single write port: sequencer owns it while busy, else port A
   always_comb begin
      we    = 1'b0;
      waddr = a_addr;
      wdata = (a_mem & ~a_wren) | (a_wrdata & a_wren);
      if (busy) begin
         we    = 1'b1;
         waddr = cnt_q;
         wdata = '0;
      end else if (!reset && (|a_wren)) begin
         we = 1'b1;
      end
   end

   // Storage array, no reset so it maps onto LUT RAM
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   generate
      if (READ_REG != 0) begin : g_reg
         logic [WIDTH-1:0] a_rd_q;
         logic [WIDTH-1:0] b_rd_q;

         // Read registers capture pre-write data, zero while clearing
         always_ff @(posedge clk) begin
            if (reset || busy) begin
               a_rd_q <= '0;
               b_rd_q <= '0;
            end else begin
               a_rd_q <= a_mem;
               b_rd_q <= b_mem;
            end
         end

         assign a_rddata = a_rd_q;
         assign b_rddata = b_rd_q;
      end else begin : g_async
         assign a_rddata = busy ? '0 : a_mem;
         assign b_rddata = busy ? '0 : b_mem;
      end
   endgenerate

endmodule

// File: tb/tb_distram_clr.sv
// tb_distram_clr: three distram_clr instances checked against a model.
// u0: 256x32 async, u1: 256x32 registered, u2: 16x32 async.
module tb_distram_clr;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [NI];
   logic        clr [NI];
   logic [7:0]  aa  [NI];
   logic [7:0]  ba  [NI];
   logic [31:0] wd  [NI];
   logic [31:0] wen [NI];
   wire         busy [NI];
   wire  [31:0] ard  [NI];
   wire  [31:0] brd  [NI];

   distram_clr #(.WIDTH(32), .DEPTH_LOG2(8), .READ_REG(0)) u0 (
      .clk(clk), .reset(rst[0]), .clear(clr[0]), .busy(busy[0]),
      .a_addr(aa[0]), .a_rddata(ard[0]), .a_wrdata(wd[0]),
      .a_wren(wen[0]), .b_addr(ba[0]), .b_rddata(brd[0]));

   distram_clr #(.WIDTH(32), .DEPTH_LOG2(8), .READ_REG(1)) u1 (
      .clk(clk), .reset(rst[1]), .clear(clr[1]), .busy(busy[1]),
      .a_addr(aa[1]), .a_rddata(ard[1]), .a_wrdata(wd[1]),
      .a_wren(wen[1]), .b_addr(ba[1]), .b_rddata(brd[1]));

   distram_clr #(.WIDTH(32), .DEPTH_LOG2(4), .READ_REG(0)) u2 (
      .clk(clk), .reset(rst[2]), .clear(clr[2]), .busy(busy[2]),
      .a_addr(aa[2][3:0]), .a_rddata(ard[2]), .a_wrdata(wd[2]),
      .a_wren(wen[2]), .b_addr(ba[2][3:0]), .b_rddata(brd[2]));

   // behavioural model: contents, remaining busy cycles, read regs
   logic [31:0] mm   [NI][256];
   int          left [NI];
   logic [31:0] ra_m [NI];
   logic [31:0] rb_m [NI];
   int          bcnt [NI];
   bit          armed;
   int          n_chk;
   int          n_fail;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] m;
      logic [7:0]  b;
      logic [31:0] ea;
      logic [31:0] eb;
   } vec_t;

   vec_t tv [8];

   function automatic int dep(int i);
      return (i == 2) ? 16 : 256;
   endfunction

   function automatic bit rr(int i);
      return (i == 1);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic half_check();
      @(negedge clk);
      if (armed) begin
         for (int i = 0; i < NI; i++) begin
            logic        eb;
            logic [31:0] xa;
            logic [31:0] xb;
            int          m;
            m  = dep(i) - 1;
            eb = (left[i] > 0);
            if (rr(i)) begin
               xa = ra_m[i];
               xb = rb_m[i];
            end else begin
               xa = eb ? 32'h0 : mm[i][int'(aa[i]) & m];
               xb = eb ? 32'h0 : mm[i][int'(ba[i]) & m];
            end
            chk($sformatf("u%0d busy", i), {31'b0, busy[i]}, {31'b0, eb});
            chk($sformatf("u%0d a_rddata", i), ard[i], xa);
            chk($sformatf("u%0d b_rddata", i), brd[i], xb);
            if (busy[i]) bcnt[i]++;
         end
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
         int m;
         int a;
         int b;
         m = dep(i) - 1;
         a = int'(aa[i]) & m;
         b = int'(ba[i]) & m;
         if (rr(i)) begin
            if (rst[i] || left[i] > 0) begin
               ra_m[i] = '0;
               rb_m[i] = '0;
            end else begin
               ra_m[i] = mm[i][a];
               rb_m[i] = mm[i][b];
            end
         end
         if (rst[i]) begin
            left[i] = dep(i);
         end else if (left[i] > 0) begin
            left[i]--;
            if (left[i] == 0)
               for (int k = 0; k < 256; k++) mm[i][k] = '0;
         end else begin
            mm[i][a] = (mm[i][a] & ~wen[i]) | (wd[i] & wen[i]);
            if (clr[i]) left[i] = dep(i);
         end
      end
      #1;
   endtask

   task automatic cyc();
      half_check();
      edge_step();
   endtask

   task automatic idle_all();
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b0;
         clr[i] = 1'b0;
         wen[i] = '0;
         wd[i]  = '0;
      end
   endtask

   task automatic fill(int i, bit inv);
      for (int k = 0; k < dep(i); k++) begin
         aa[i]  = 8'(k);
         wd[i]  = inv ? ~32'(k) : 32'(k);
         wen[i] = '1;
         cyc();
      end
      wen[i] = '0;
   endtask

   task automatic scan_zero(int i);
      int nz;
      nz = 0;
      for (int k = 0; k < dep(i); k++) begin
         aa[i]  = 8'(k);
         ba[i]  = 8'(dep(i) - 1 - k);
         wen[i] = '0;
         half_check();
         if (ard[i] != 0) nz++;
         if (brd[i] != 0) nz++;
         edge_step();
      end
      chk($sformatf("u%0d scan nonzero", i), 32'(nz), 32'h0);
   endtask

   initial begin
      bit found;
      n_chk  = 0;
      n_fail = 0;
      armed  = 1'b0;
      for (int i = 0; i < NI; i++) begin
         left[i] = 0;
         ra_m[i] = '0;
         rb_m[i] = '0;
         bcnt[i] = 0;
         aa[i]   = '0;
         ba[i]   = '0;
         for (int k = 0; k < 256; k++) mm[i][k] = '0;
      end
      idle_all();

      tv[0] = '{8'h00, 32'h0, 32'h0, 8'hFF, 32'h0, 32'h0};
      tv[1] = '{8'h7F, 32'h0, 32'h0, 8'h80, 32'h0, 32'h0};
      tv[2] = '{8'h80, 32'h0, 32'h0, 8'h7F, 32'h0, 32'h0};
      tv[3] = '{8'hFF, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0};
      tv[4] = '{8'h85, 32'hDEADBEEF, 32'hFFFFFFFF, 8'h85,
                32'h0, 32'h0};
      tv[5] = '{8'h85, 32'h12345678, 32'h0000FFFF, 8'h85,
                32'hDEADBEEF, 32'hDEADBEEF};
      tv[6] = '{8'h05, 32'h0, 32'h0, 8'h85, 32'h0, 32'hDEAD5678};
      tv[7] = '{8'h85, 32'h0, 32'h0, 8'h05, 32'hDEAD5678, 32'h0};

      // reset-clear: one reset cycle, then count busy
      for (int i = 0; i < NI; i++) rst[i] = 1'b1;
      cyc();
      armed = 1'b1;
      idle_all();
      for (int i = 0; i < NI; i++) bcnt[i] = 0;
      repeat (260) cyc();
      chk("u0 reset busy len", 32'(bcnt[0]), 32'd256);
      chk("u1 reset busy len", 32'(bcnt[1]), 32'd256);
      chk("u2 reset busy len", 32'(bcnt[2]), 32'd16);

      // table: zero reads, masked write, no forwarding
      for (int v = 0; v < 8; v++) begin
         aa[0]  = tv[v].a;
         wd[0]  = tv[v].d;
         wen[0] = tv[v].m;
         ba[0]  = tv[v].b;
         half_check();
         chk($sformatf("vec%0d a_rddata", v), ard[0], tv[v].ea);
         chk($sformatf("vec%0d b_rddata", v), brd[0], tv[v].eb);
         edge_step();
      end
      idle_all();

      // registered read: old value first, new value one cycle later
      aa[1]  = 8'h10;
      ba[1]  = 8'h10;
      wd[1]  = 32'hA5A5A5A5;
      wen[1] = '1;
      cyc();
      wen[1] = '0;
      half_check();
      chk("regrd b N+1", brd[1], 32'h0);
      edge_step();
      half_check();
      chk("regrd b N+2", brd[1], 32'hA5A5A5A5);
      chk("regrd a N+2", ard[1], 32'hA5A5A5A5);
      edge_step();

      // clear request with dropped write and an ignored second clear
      fill(0, 1'b0);
      clr[0]  = 1'b1;
      bcnt[0] = 0;
      cyc();
      clr[0] = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         aa[0]  = 8'($urandom);
         ba[0]  = 8'($urandom);
         wen[0] = '0;
         if (k == 5) begin
            aa[0]  = 8'h03;
            wd[0]  = 32'hFFFFFFFF;
            wen[0] = '1;
         end
         clr[0] = (k == 100);
         cyc();
      end
      idle_all();
      chk("clear busy len", 32'(bcnt[0]), 32'd256);
      aa[0] = 8'h03;
      half_check();
      chk("entry 03 after clear", ard[0], 32'h0);
      edge_step();
      scan_zero(0);

      // reset in the middle of a clear restarts the sequence
      fill(0, 1'b1);
      clr[0] = 1'b1;
      cyc();
      clr[0] = 1'b0;
      repeat (49) cyc();
      rst[0] = 1'b1;
      cyc();
      rst[0]  = 1'b0;
      bcnt[0] = 0;
      repeat (300) cyc();
      chk("reset mid-clear busy len", 32'(bcnt[0]), 32'd256);
      scan_zero(0);

      // boundary: last busy write dropped, first idle write lands
      fill(2, 1'b0);
      clr[2]  = 1'b1;
      bcnt[2] = 0;
      cyc();
      clr[2] = 1'b0;
      found  = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         wen[2] = '1;
         if (!busy[2]) begin
            found = 1'b1;
            aa[2] = 8'h09;
            wd[2] = 32'h00000099;
         end else begin
            aa[2] = 8'h07;
            wd[2] = 32'h00000077;
         end
         cyc();
      end
      chk("boundary busy fell", {31'b0, found}, 32'h1);
      wen[2] = '0;
      aa[2]  = 8'h09;
      ba[2]  = 8'h07;
      half_check();
      chk("boundary first idle write", ard[2], 32'h00000099);
      chk("boundary last busy write", brd[2], 32'h0);
      edge_step();
      chk("u2 clear busy len", 32'(bcnt[2]), 32'd16);

      // random traffic on all instances against the model
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < NI; i++) begin
            rst[i] = ($urandom_range(0, 299) == 0);
            clr[i] = ($urandom_range(0, 149) == 0);
            aa[i]  = 8'($urandom);
            ba[i]  = 8'($urandom);
            wd[i]  = $urandom;
            case ($urandom_range(0, 3))
               0:       wen[i] = '1;
               1:       wen[i] = $urandom;
               default: wen[i] = '0;
            endcase
         end
         cyc();
      end
      idle_all();
      repeat (4) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
